// File: rtl/tour_cmd.sv
// rtl/tour_cmd.sv - knight's tour playback sequencer muxed with UART command pass-through
// Optional illegal-move detection: define TOUR_CMD_ILLEGAL_CHK_EN.
module tour_cmd #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        err_move
);

  typedef enum logic [2:0] {IDLE, VERT, HOLDV, HORZ, HOLDH} state_t;

  state_t      state;
  logic        dx_neg, dy_neg;
  logic [1:0]  dx_mag, dy_mag;
  logic [15:0] vert_cmd, horz_cmd;
  logic        last_move;

  // Lowest set bit wins; an empty move decodes to zero deltas (heading N/E).
  always_comb begin
    {dx_neg, dx_mag, dy_neg, dy_mag} = 6'b0;
    casez (move)
      8'b???????1: {dx_neg, dx_mag, dy_neg, dy_mag} = {1'b0, 2'd1, 1'b0, 2'd2};
      8'b??????10: {dx_neg, dx_mag, dy_neg, dy_mag} = {1'b1, 2'd1, 1'b0, 2'd2};
      8'b?????100: {dx_neg, dx_mag, dy_neg, dy_mag} = {1'b1, 2'd2, 1'b0, 2'd1};
      8'b????1000: {dx_neg, dx_mag, dy_neg, dy_mag} = {1'b1, 2'd2, 1'b1, 2'd1};
      8'b???10000: {dx_neg, dx_mag, dy_neg, dy_mag} = {1'b1, 2'd1, 1'b1, 2'd2};
      8'b??100000: {dx_neg, dx_mag, dy_neg, dy_mag} = {1'b0, 2'd1, 1'b1, 2'd2};
      8'b?1000000: {dx_neg, dx_mag, dy_neg, dy_mag} = {1'b0, 2'd2, 1'b1, 2'd1};
      8'b10000000: {dx_neg, dx_mag, dy_neg, dy_mag} = {1'b0, 2'd2, 1'b0, 2'd1};
      default:     {dx_neg, dx_mag, dy_neg, dy_mag} = 6'b0;
    endcase
  end

  assign vert_cmd  = {4'h2, (dy_neg ? 8'h7F : 8'h00), 2'b00, dy_mag};
  assign horz_cmd  = {4'h3, (dx_neg ? 8'h3F : 8'hBF), 2'b00, dx_mag};
  assign last_move = (mv_indx == 5'(NUM_MOVES - 1));

`ifdef TOUR_CMD_ILLEGAL_CHK_EN
  logic move_illegal;
  logic err_move_q;
  assign move_illegal = (move == 8'h00) || ((move & (move - 8'd1)) != 8'h00);
  assign err_move     = err_move_q;
`else
  assign err_move = 1'b0;
`endif

  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = 8'hA5;
    case (state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = 8'h5A;
      end
      VERT: begin
        cmd = vert_cmd;
`ifdef TOUR_CMD_ILLEGAL_CHK_EN
        cmd_rdy = ~move_illegal;
`else
        cmd_rdy = 1'b1;
`endif
      end
      HOLDV: cmd = vert_cmd;
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
      end
      HOLDH: begin
        cmd  = horz_cmd;
        resp = last_move ? 8'h5A : 8'hA5;
      end
      default: cmd = cmd_UART;
    endcase
  end

  // send_resp is only honoured in the HOLD states, so a coincident ack cannot skip a hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= 5'd0;
`ifdef TOUR_CMD_ILLEGAL_CHK_EN
      err_move_q <= 1'b0;
`endif
    end else begin
`ifdef TOUR_CMD_ILLEGAL_CHK_EN
      err_move_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start_tour) begin
            mv_indx <= 5'd0;
            state   <= VERT;
          end
        end
        VERT: begin
`ifdef TOUR_CMD_ILLEGAL_CHK_EN
          if (move_illegal) begin
            err_move_q <= 1'b1;
            state      <= IDLE;
          end else if (clr_cmd_rdy) begin
            state <= HOLDV;
          end
`else
          if (clr_cmd_rdy) state <= HOLDV;
`endif
        end
        HOLDV: if (send_resp) state <= HORZ;
        HORZ:  if (clr_cmd_rdy) state <= HOLDH;
        HOLDH: begin
          if (send_resp) begin
            if (last_move) begin
              state <= IDLE;
            end else begin
              mv_indx <= mv_indx + 5'd1;
              state   <= VERT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tour_cmd.sv
// tb/tb_tour_cmd.sv - scoreboard bench for tour_cmd with a knight-move reference model
module tb_tour_cmd;

  localparam int NUM_MOVES = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_tour = 1'b0;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = 16'h0;
  logic        cmd_rdy_UART = 1'b0;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        err_move;

  logic        resp_clr = 1'b0;
  logic        uart_clr = 1'b0;
  logic [7:0]  mv_arr [32];

  assign clr_cmd_rdy = resp_clr | uart_clr;
  assign move        = mv_arr[mv_indx];

  tour_cmd #(.NUM_MOVES(NUM_MOVES)) dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .resp(resp), .err_move(err_move)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    int          idx;
    logic [7:0]  resp;
    bit          stop;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   n_cmds = 0;
  int   err_cnt = 0;
  bit   mon_en = 1'b0;
  bit   busy = 1'b0;
  bit   parked = 1'b0;

  // Knight deltas per move bit: x right-positive, y north-positive.
  int dxt [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dyt [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_cmd(input logic [7:0] m, input bit horiz);
    int dx = 0;
    int dy = 0;
    int d;
    logic [7:0] hd;
    logic [3:0] sq;
    for (int b = 7; b >= 0; b--)
      if (m[b]) begin
        dx = dxt[b];
        dy = dyt[b];
      end
    d = horiz ? dx : dy;
    if (horiz) hd = (d < 0) ? 8'h3F : 8'hBF;
    else       hd = (d < 0) ? 8'h7F : 8'h00;
    sq = 4'((d < 0) ? -d : d);
    return {(horiz ? 4'h3 : 4'h2), hd, sq};
  endfunction

  task automatic push_moves(input int nmoves, input bit stop_at_vert);
    exp_t e;
    for (int i = 0; i < nmoves; i++) begin
      e.cmd = model_cmd(mv_arr[i], 1'b0); e.idx = i; e.resp = 8'hA5; e.stop = 1'b0;
      sbq.push_back(e);
      e.cmd = model_cmd(mv_arr[i], 1'b1);
      e.resp = (i == NUM_MOVES - 1) ? 8'h5A : 8'hA5;
      sbq.push_back(e);
    end
    if (stop_at_vert) begin
      e.cmd = model_cmd(mv_arr[nmoves], 1'b0); e.idx = nmoves; e.resp = 8'hA5; e.stop = 1'b1;
      sbq.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start_tour = 1'b1;
    @(negedge clk) start_tour = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 4000 && (sbq.size() != 0 || busy); k++) @(negedge clk);
    check("drain_timeout", 32'(sbq.size() == 0 && !busy), 1);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) if (err_move === 1'b1) err_cnt++;

  // Command-processor model: accepts each tour cmd, checks it, then acks.
  initial begin
    exp_t e;
    send_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && cmd_rdy) begin
        busy = 1'b1;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got cmd %0h with empty scoreboard", cmd);
        end else begin
          e = sbq.pop_front();
          n_cmds++;
          check("cmd", 32'(cmd), 32'(e.cmd));
          check("mv_indx", 32'(mv_indx), e.idx);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          check("cmd_rdy_held", 32'(cmd_rdy), 1);
          resp_clr = 1'b1;
          if ($urandom_range(0, 3) == 0) send_resp = 1'b1;
          #1 check("clr_uart_blocked", 32'(clr_cmd_rdy_UART), 0);
          @(negedge clk);
          resp_clr = 1'b0;
          send_resp = 1'b0;
          check("hold_rdy_low", 32'(cmd_rdy), 0);
          if (e.stop) begin
            parked = 1'b1;
            @(negedge rst_n);
            parked = 1'b0;
          end else begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            check("resp", 32'(resp), 32'(e.resp));
            send_resp = 1'b1;
            @(negedge clk);
            send_resp = 1'b0;
          end
        end
        busy = 1'b0;
      end
    end
  end

  initial begin
    int k;
    logic [15:0] r;
    for (int i = 0; i < 32; i++) mv_arr[i] = 8'h00;

    cmd_rdy_UART = 1'b1;
    cmd_UART = 16'h1234;
    #3;
    check("rst_mv_indx", 32'(mv_indx), 0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 1);
    check("rst_cmd", 32'(cmd), 32'h1234);
    check("rst_resp", 32'(resp), 32'h5A);
    check("rst_err_move", 32'(err_move), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmd_rdy_UART = 1'b0;

    @(negedge clk);
    cmd_UART = 16'h2003;
    cmd_rdy_UART = 1'b1;
    #1;
    check("uart_cmd", 32'(cmd), 32'h2003);
    check("uart_rdy", 32'(cmd_rdy), 1);
    uart_clr = 1'b1;
    #1 check("uart_clr", 32'(clr_cmd_rdy_UART), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      r = 16'($urandom);
      cmd_UART = r;
      cmd_rdy_UART = 1'($urandom);
      uart_clr = 1'($urandom);
      #1;
      check("uart_cmd_rand", 32'(cmd), 32'(r));
      check("uart_rdy_rand", 32'(cmd_rdy), 32'(cmd_rdy_UART));
      check("uart_clr_rand", 32'(clr_cmd_rdy_UART), 32'(uart_clr));
    end
    @(negedge clk);
    cmd_rdy_UART = 1'b0;
    uart_clr = 1'b0;

    // Full tour: first two moves are the hand-checked cases, rest random one-hot.
    mv_arr[0] = 8'h01;
    mv_arr[1] = 8'h08;
    for (int i = 2; i < NUM_MOVES; i++) mv_arr[i] = 8'h01 << $urandom_range(0, 7);
    push_moves(NUM_MOVES, 1'b0);
    n_cmds = 0;
    mon_en = 1'b1;
    pulse_start();
    check("rdy_after_start", 32'(cmd_rdy), 1);
    repeat (30) @(negedge clk);
    pulse_start();
    drain();
    check("tour_cmd_count", n_cmds, 2 * NUM_MOVES);
    check("tour_end_mv_indx", 32'(mv_indx), NUM_MOVES - 1);
    check("tour_end_resp", 32'(resp), 32'h5A);
    mon_en = 1'b0;
    r = 16'($urandom);
    cmd_UART = r;
    cmd_rdy_UART = 1'b1;
    #1;
    check("post_tour_rdy", 32'(cmd_rdy), 1);
    check("post_tour_cmd", 32'(cmd), 32'(r));
    @(negedge clk);
    cmd_rdy_UART = 1'b0;

    // Abandon a tour with reset while holding the vertical leg of move 7.
    for (int i = 0; i < NUM_MOVES; i++) mv_arr[i] = 8'h01 << $urandom_range(0, 7);
    push_moves(7, 1'b1);
    mon_en = 1'b1;
    pulse_start();
    for (k = 0; k < 4000 && !parked; k++) @(negedge clk);
    check("park_timeout", 32'(parked), 1);
    @(negedge clk);
    check("holdv_mv_indx", 32'(mv_indx), 7);
    check("holdv_rdy", 32'(cmd_rdy), 0);
    check("holdv_resp", 32'(resp), 32'hA5);
    mon_en = 1'b0;
    cmd_rdy_UART = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_mv_indx", 32'(mv_indx), 0);
    check("mid_rst_rdy", 32'(cmd_rdy), 1);
    check("mid_rst_resp", 32'(resp), 32'h5A);
    check("mid_rst_sb_empty", 32'(sbq.size()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cmd_rdy_UART = 1'b0;
    @(negedge clk);

`ifdef TOUR_CMD_ILLEGAL_CHK_EN
    for (int i = 0; i < NUM_MOVES; i++) mv_arr[i] = 8'h01 << $urandom_range(0, 7);
    mv_arr[4] = 8'h03;
    err_cnt = 0;
    push_moves(4, 1'b0);
    mon_en = 1'b1;
    pulse_start();
    drain();
    repeat (5) @(negedge clk);
    check("illegal_err_pulses", err_cnt, 1);
    check("illegal_mv_indx", 32'(mv_indx), 4);
    check("illegal_idle_resp", 32'(resp), 32'h5A);
    check("illegal_no_rdy", 32'(cmd_rdy), 0);
`else
    // Empty and multi-bit moves must decode by lowest set bit and keep going.
    for (int i = 0; i < NUM_MOVES; i++) mv_arr[i] = 8'($urandom_range(0, 255));
    mv_arr[2] = 8'h00;
    mv_arr[3] = 8'h03;
    mv_arr[5] = 8'hC0;
    push_moves(NUM_MOVES, 1'b0);
    n_cmds = 0;
    mon_en = 1'b1;
    pulse_start();
    drain();
    check("odd_tour_cmd_count", n_cmds, 2 * NUM_MOVES);
    check("odd_tour_mv_indx", 32'(mv_indx), NUM_MOVES - 1);
    check("err_move_tied_low", err_cnt, 0);
`endif
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
